axis_rr_arbiter: RTL and testbench

//  Round-robin arbiter merging NUM_PORTS 512-bit AXI-Stream command sources into one stream

---
 rtl/axis_arb_pkg.sv | 41 ++++
 rtl/rr_priority_picker.sv | 46 ++++
 rtl/axis_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared widths, lock state type and round-robin pick helper
//
// Purpose : common definitions for the AXIS round-robin command arbiter.
//           rr_pick(req, last) returns a one-hot grant for the first set
//           request bit found searching last+1, last+2, ... with wrap.
//           Ports that do not exist must present req=0, so searching modulo
//           MAX_PORTS gives the same order as searching modulo NUM_PORTS.
// Ports   : none (package)
package axis_arb_pkg;

   localparam int AXIS_TDATA_WIDTH = 512;
   localparam int STAT_WIDTH       = 32;
   localparam int MAX_PORTS        = 8;
   localparam int MAX_IDX_W        = $clog2(MAX_PORTS);
   localparam int BURST_W          = 5;

   typedef enum logic {
      LOCK_UNLOCKED = 1'b0,
      LOCK_LOCKED   = 1'b1
   } lock_state_e;

   function automatic logic [MAX_PORTS-1:0] rr_pick(
      input logic [MAX_PORTS-1:0] req,
      input logic [MAX_IDX_W-1:0] last
   );
      logic [MAX_PORTS-1:0] grant;
      logic                 found;
      logic [MAX_IDX_W-1:0] idx;
      grant = '0;
      found = 1'b0;
      for (int s = 1; s <= MAX_PORTS; s++) begin
         idx = MAX_IDX_W'((int'(last) + s) % MAX_PORTS);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin priority picker
//
// Purpose : picks the first requesting port after last_grant (with wrap).
//           Purely combinational; all arbitration state lives in the caller.
// Ports   : req        in   NUM_PORTS       request vector
//           last_grant in   clog2(NUM_PORTS) port granted most recently
//           onehot     out  NUM_PORTS       one-hot grant, zero if no request
//           index      out  clog2(NUM_PORTS) binary index of onehot
module rr_priority_picker
   import axis_arb_pkg::*;
#(
   parameter  int NUM_PORTS = 4,
   localparam int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     last_grant,
   output logic [NUM_PORTS-1:0] onehot,
   output logic [IDX_W-1:0]     index
);

   logic [MAX_PORTS-1:0] req_ext;
   logic [MAX_PORTS-1:0] pick;
   logic [MAX_IDX_W-1:0] last_ext;

   always_comb begin
      req_ext                = '0;
      req_ext[NUM_PORTS-1:0] = req;
   end

   assign last_ext = MAX_IDX_W'(last_grant);
   assign pick     = rr_pick(req_ext, last_ext);

   // Bits above NUM_PORTS can never be set because their requests are tied
   // low; folding them in keeps the full-width pick result consumed.
   assign onehot = pick[NUM_PORTS-1:0] & {NUM_PORTS{~|(pick >> NUM_PORTS)}};

   always_comb begin
      index = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (onehot[i]) begin
            index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - round-robin AXIS command arbiter with burst lock
//
// Purpose : merges NUM_PORTS AXI-Stream command sources into one registered
//           stream. A grant may be kept for up to MAX_BURST consecutive beats
//           while the holder keeps TVALID high. Optional per-port beat
//           counters are built when AXIS_ARB_STATS_EN is defined; otherwise
//           STAT_BEATS is tied to zero.
// Ports   : clk            in   single clock
//           rst            in   synchronous active-high reset
//           S_AXIS_TDATA   in   NUM_PORTS*TDATA_WIDTH, port i at [i*W +: W]
//           S_AXIS_TVALID  in   per-port valid
//           S_AXIS_TREADY  out  per-port ready, one-hot or zero
//           M_AXIS_TDATA   out  merged beat (registered)
//           M_AXIS_TVALID  out  registered valid
//           M_AXIS_TREADY  in   downstream ready
//           M_AXIS_TID     out  source port of the current beat
//           STAT_BEATS     out  NUM_PORTS*32 accepted-beat counters
module axis_rr_arbiter
   import axis_arb_pkg::*;
#(
   parameter  int NUM_PORTS   = 4,
   parameter  int TDATA_WIDTH = AXIS_TDATA_WIDTH,
   parameter  int MAX_BURST   = 4,
   localparam int IDX_W       = $clog2(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS*TDATA_WIDTH-1:0] S_AXIS_TDATA,
   input  logic [NUM_PORTS-1:0]            S_AXIS_TVALID,
   output logic [NUM_PORTS-1:0]            S_AXIS_TREADY,
   output logic [TDATA_WIDTH-1:0]          M_AXIS_TDATA,
   output logic                            M_AXIS_TVALID,
   input  logic                            M_AXIS_TREADY,
   output logic [IDX_W-1:0]                M_AXIS_TID,
   output logic [NUM_PORTS*STAT_WIDTH-1:0] STAT_BEATS
);

   lock_state_e            lock_q, lock_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [BURST_W-1:0]     burst_q, burst_d;
   logic [BURST_W-1:0]     burst_inc;

   logic                   load;
   logic                   hold;
   logic                   xfer;
   logic [NUM_PORTS-1:0]   rr_onehot;
   logic [IDX_W-1:0]       rr_index;
   logic [NUM_PORTS-1:0]   grant_onehot;
   logic [IDX_W-1:0]       grant_index;
   logic [TDATA_WIDTH-1:0] sel_data;

   // The output register can take a new beat when empty or being drained.
   assign load = !M_AXIS_TVALID || M_AXIS_TREADY;

   // A lock only holds while its owner still has data; otherwise the normal
   // round-robin pick is used in the same cycle so no bubble appears.
   assign hold = (lock_q == LOCK_LOCKED) && S_AXIS_TVALID[last_q];

   rr_priority_picker #(
      .NUM_PORTS (NUM_PORTS)
   ) u_picker (
      .req        (S_AXIS_TVALID),
      .last_grant (last_q),
      .onehot     (rr_onehot),
      .index      (rr_index)
   );

   always_comb begin
      grant_onehot = rr_onehot;
      grant_index  = rr_index;
      if (hold) begin
         grant_onehot         = '0;
         grant_onehot[last_q] = 1'b1;
         grant_index          = last_q;
      end
   end

   // Grants only ever go to valid ports, so a nonzero grant while loading is
   // exactly one handshake. Ready is held off during reset so no source sees
   // a beat accepted that the reset then discards.
   assign xfer          = !rst && load && (|grant_onehot);
   assign S_AXIS_TREADY = xfer ? grant_onehot : '0;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_onehot[i]) begin
            sel_data = S_AXIS_TDATA[i*TDATA_WIDTH +: TDATA_WIDTH];
         end
      end
   end

   assign burst_inc = burst_q + 1'b1;

   // Lock FSM next state; changes only when a beat is actually accepted.
   always_comb begin
      lock_d  = lock_q;
      last_d  = last_q;
      burst_d = burst_q;
      if (xfer) begin
         if (hold) begin
            burst_d = burst_inc;
            if (burst_inc == BURST_W'(MAX_BURST)) begin
               lock_d  = LOCK_UNLOCKED;
               burst_d = '0;
            end
         end else begin
            last_d  = grant_index;
            burst_d = BURST_W'(1);
            lock_d  = (MAX_BURST > 1) ? LOCK_LOCKED : LOCK_UNLOCKED;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q        <= LOCK_UNLOCKED;
         last_q        <= IDX_W'(NUM_PORTS - 1);
         burst_q       <= '0;
         M_AXIS_TVALID <= 1'b0;
         M_AXIS_TDATA  <= '0;
         M_AXIS_TID    <= '0;
      end else begin
         lock_q  <= lock_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         if (xfer) begin
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= sel_data;
            M_AXIS_TID    <= grant_index;
         end else if (load) begin
            M_AXIS_TVALID <= 1'b0;
         end
      end
   end

`ifdef AXIS_ARB_STATS_EN
   logic [STAT_WIDTH-1:0] stat_cnt [NUM_PORTS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            stat_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (xfer && grant_onehot[i]) begin
               stat_cnt[i] <= stat_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      STAT_BEATS = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         STAT_BEATS[i*STAT_WIDTH +: STAT_WIDTH] = stat_cnt[i];
      end
   end
`else
   assign STAT_BEATS = '0;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - self-checking bench for axis_rr_arbiter
module tb_axis_rr_arbiter;

   localparam int NP  = 4;
   localparam int W   = 512;
   localparam int IDW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic m_ready = 1'b0;

   logic [NP*W-1:0] s_tdata  [2];
   logic [NP-1:0]   s_tvalid [2];
   wire  [NP-1:0]   s_tready [2];
   wire  [W-1:0]    m_tdata  [2];
   wire             m_tvalid [2];
   wire  [IDW-1:0]  m_tid    [2];
   wire  [NP*32-1:0] stat    [2];

   always #5 clk = ~clk;

   // Instance 0 uses burst lock of 4, instance 1 is pure per-beat round robin.
   axis_rr_arbiter #(.NUM_PORTS(NP), .TDATA_WIDTH(W), .MAX_BURST(4)) dut_b4 (
      .clk(clk), .rst(rst),
      .S_AXIS_TDATA(s_tdata[0]), .S_AXIS_TVALID(s_tvalid[0]), .S_AXIS_TREADY(s_tready[0]),
      .M_AXIS_TDATA(m_tdata[0]), .M_AXIS_TVALID(m_tvalid[0]), .M_AXIS_TREADY(m_ready),
      .M_AXIS_TID(m_tid[0]), .STAT_BEATS(stat[0])
   );

   axis_rr_arbiter #(.NUM_PORTS(NP), .TDATA_WIDTH(W), .MAX_BURST(1)) dut_b1 (
      .clk(clk), .rst(rst),
      .S_AXIS_TDATA(s_tdata[1]), .S_AXIS_TVALID(s_tvalid[1]), .S_AXIS_TREADY(s_tready[1]),
      .M_AXIS_TDATA(m_tdata[1]), .M_AXIS_TVALID(m_tvalid[1]), .M_AXIS_TREADY(m_ready),
      .M_AXIS_TID(m_tid[1]), .STAT_BEATS(stat[1])
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // source side
   int unsigned seq    [2][NP];
   int unsigned lim    [2][NP];
   bit          en     [NP];
   bit          rnd = 1'b0;
   bit          hs     [2][NP];
   int unsigned tx_cnt [2][NP];
   int unsigned rx_next[2][NP];
   int          log_tid[2][$];
   int          log_cyc[2][$];

   // model of the arbiter outputs
   bit             mv     [2] = '{1'b0, 1'b0};
   logic [W-1:0]   md     [2] = '{'0, '0};
   int             mt     [2] = '{0, 0};
   int             mlast  [2] = '{NP-1, NP-1};
   int             mrun   [2] = '{0, 0};
   bit             mlocked[2] = '{1'b0, 1'b0};
   int unsigned    mcnt   [2][NP];

   function automatic int mb_of(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   function automatic logic [W-1:0] mk(input int p, input int unsigned s);
      logic [W-1:0] d;
      d = '0;
      d[W-1 -: 8] = 8'hA5;
      d[47:40]    = 8'(p);
      d[31:0]     = s;
      return d;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One cycle of the model: compare, observe handshakes, then advance.
   task automatic model_cycle(input int k);
      logic [NP-1:0] v;
      logic [NP-1:0] exp_tr;
      bit  load, hold, found;
      int  g, p, t;
      v = s_tvalid[k];
      chk($sformatf("m_tvalid%0d", k), m_tvalid[k], mv[k]);
      if (mv[k]) begin
         chk($sformatf("m_tid%0d", k), m_tid[k], mt[k]);
         chk($sformatf("m_tdata%0d", k), m_tdata[k], md[k]);
      end
      for (int q = 0; q < NP; q++) begin
`ifdef AXIS_ARB_STATS_EN
         chk($sformatf("stat%0d_%0d", k, q), stat[k][q*32 +: 32], mcnt[k][q]);
`else
         chk($sformatf("stat%0d_%0d", k, q), stat[k][q*32 +: 32], 0);
`endif
      end
      load  = !mv[k] || m_ready;
      hold  = mlocked[k] && v[mlast[k]];
      found = 1'b0;
      g     = 0;
      if (hold) begin
         g = mlast[k];
         found = 1'b1;
      end else begin
         for (int s = 1; s <= NP; s++) begin
            p = (mlast[k] + s) % NP;
            if (!found && v[p]) begin
               g = p;
               found = 1'b1;
            end
         end
      end
      exp_tr = (!rst && load && found) ? (NP'(1) << g) : '0;
      chk($sformatf("s_tready%0d", k), s_tready[k], exp_tr);
      for (int q = 0; q < NP; q++) hs[k][q] = v[q] && s_tready[k][q];
      if (!rst && m_tvalid[k] && m_ready) begin
         t = int'(m_tid[k]);
         chk($sformatf("sb_seq%0d_p%0d", k, t), m_tdata[k][31:0], rx_next[k][t]);
         chk($sformatf("sb_port%0d", k), m_tdata[k][47:40], t);
         rx_next[k][t]++;
         log_tid[k].push_back(t);
         log_cyc[k].push_back(cyc);
      end
      if (rst) begin
         mv[k] = 1'b0; md[k] = '0; mt[k] = 0;
         mlast[k] = NP - 1; mrun[k] = 0; mlocked[k] = 1'b0;
         for (int q = 0; q < NP; q++) begin
            mcnt[k][q] = 0; tx_cnt[k][q] = 0; rx_next[k][q] = seq[k][q];
         end
      end else begin
         for (int q = 0; q < NP; q++) if (hs[k][q]) tx_cnt[k][q]++;
         if (load && found) begin
            mv[k] = 1'b1;
            md[k] = s_tdata[k][g*W +: W];
            mt[k] = g;
            mcnt[k][g]++;
            if (hold) begin
               mrun[k]++;
               if (mrun[k] == mb_of(k)) begin
                  mlocked[k] = 1'b0;
                  mrun[k] = 0;
               end
            end else begin
               mlast[k] = g;
               mrun[k] = 1;
               mlocked[k] = (mb_of(k) > 1);
            end
         end else if (load) begin
            mv[k] = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      model_cycle(0);
      model_cycle(1);
   end

   // Advance one clock: sources retire accepted beats and present the next.
   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < NP; p++) begin
            if (hs[k][p]) seq[k][p]++;
            if (rnd) begin
               if (!(s_tvalid[k][p] && !hs[k][p])) s_tvalid[k][p] = 1'($urandom_range(0, 1));
            end else begin
               s_tvalid[k][p] = en[p] && (seq[k][p] < lim[k][p]);
            end
            s_tdata[k][p*W +: W] = mk(p, seq[k][p]);
         end
      end
      if (rnd) m_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic clear_logs();
      for (int k = 0; k < 2; k++) begin
         log_tid[k].delete();
         log_cyc[k].delete();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rnd = 1'b0;
      m_ready = 1'b0;
      for (int p = 0; p < NP; p++) en[p] = 1'b0;
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < NP; p++) lim[k][p] = 32'hFFFF_FFFF;
      step();
      step();
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic chk_log(input int k, input string nm, input int exp[$], input bit contig);
      int a;
      for (int i = 0; i < exp.size(); i++) begin
         a = (i < log_tid[k].size()) ? log_tid[k][i] : 99;
         chk($sformatf("%s_tid[%0d]", nm, i), a, exp[i]);
         if (contig) begin
            a = (i < log_cyc[k].size()) ? (log_cyc[k][i] - log_cyc[k][0]) : -1;
            chk($sformatf("%s_gap[%0d]", nm, i), a, i);
         end
      end
   endtask

   logic [W-1:0]   held_d [2];
   logic [IDW-1:0] held_t [2];
   int             e[$];

   initial begin
      for (int k = 0; k < 2; k++) begin
         s_tvalid[k] = '0;
         for (int p = 0; p < NP; p++) begin
            seq[k][p] = 0; lim[k][p] = 32'hFFFF_FFFF; hs[k][p] = 1'b0;
            tx_cnt[k][p] = 0; rx_next[k][p] = 0; mcnt[k][p] = 0;
            s_tdata[k][p*W +: W] = mk(p, 0);
         end
      end
      for (int p = 0; p < NP; p++) en[p] = 1'b0;

      // reset state
      step();
      step();
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_tvalid", m_tvalid[k], 0);
         chk("rst_tdata", m_tdata[k], 0);
         chk("rst_tid", m_tid[k], 0);
         chk("rst_tready", s_tready[k], 0);
         chk("rst_stat", stat[k], 0);
      end

      // 1: all ports valid, per-beat and burst rotation
      rst = 1'b0;
      clear_logs();
      for (int p = 0; p < NP; p++) en[p] = 1'b1;
      m_ready = 1'b1;
      repeat (8) step();
      e = '{0, 1, 2, 3, 0};          chk_log(1, "t1_b1", e, 1'b1);
      e = '{0, 0, 0, 0, 1};          chk_log(0, "t1_b4", e, 1'b1);

      // 2a: ports 1 and 2 always valid
      do_reset();
      en[1] = 1'b1; en[2] = 1'b1;
      m_ready = 1'b1;
      repeat (12) step();
      e = '{1, 1, 1, 1, 2, 2, 2, 2, 1}; chk_log(0, "t2a_b4", e, 1'b1);
      e = '{1, 2, 1, 2};                chk_log(1, "t2a_b1", e, 1'b1);

      // 2b: port 1 stops after two beats while holding the lock
      do_reset();
      en[1] = 1'b1; en[2] = 1'b1;
      for (int k = 0; k < 2; k++) lim[k][1] = seq[k][1] + 2;
      m_ready = 1'b1;
      repeat (10) step();
      e = '{1, 1, 2, 2, 2};          chk_log(0, "t2b_b4", e, 1'b1);

      // 3: backpressure
      do_reset();
      for (int p = 0; p < NP; p++) en[p] = 1'b1;
      m_ready = 1'b1;
      repeat (3) step();
      m_ready = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         held_d[k] = m_tdata[k];
         held_t[k] = m_tid[k];
         chk("t3_valid", m_tvalid[k], 1);
         chk("t3_a5", held_d[k][W-1 -: 8], 8'hA5);
      end
      repeat (5) begin
         step();
         #1;
         for (int k = 0; k < 2; k++) begin
            chk("t3_hold_data", m_tdata[k], held_d[k]);
            chk("t3_hold_tid", m_tid[k], held_t[k]);
            chk("t3_tready0", s_tready[k], 0);
         end
      end
      m_ready = 1'b1;
      repeat (4) step();
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < NP; p++)
            lim[k][p] = s_tvalid[k][p] ? seq[k][p] + 1 : seq[k][p];
      repeat (10) step();
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < NP; p++)
            chk($sformatf("t3_drain%0d_p%0d", k, p), rx_next[k][p], seq[k][p]);

      // 4: wrap from last_grant=3, then port 3 alone streams
      do_reset();
      en[0] = 1'b1; en[3] = 1'b1;
      for (int k = 0; k < 2; k++) lim[k][0] = seq[k][0] + 1;
      m_ready = 1'b1;
      repeat (9) step();
      e = '{0, 3, 3, 3, 3, 3, 3};
      chk_log(0, "t4_b4", e, 1'b1);
      chk_log(1, "t4_b1", e, 1'b1);

      // 5: reset while a beat is in flight
      do_reset();
      for (int p = 0; p < NP; p++) en[p] = 1'b1;
      m_ready = 1'b1;
      repeat (3) step();
      #1;
      for (int k = 0; k < 2; k++) chk("t5_busy", m_tvalid[k], 1);
      rst = 1'b1;
      step();
      #1;
      for (int k = 0; k < 2; k++) chk("t5_dropped", m_tvalid[k], 0);
      rst = 1'b0;
      clear_logs();
      repeat (4) step();
      e = '{0};
      chk_log(0, "t5_b4", e, 1'b0);
      chk_log(1, "t5_b1", e, 1'b0);

      // 6: random traffic, beat counters
      do_reset();
      rnd = 1'b1;
      repeat (1000) step();
      rnd = 1'b0;
      m_ready = 1'b1;
      step();
      step();
      #1;
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < NP; p++)
`ifdef AXIS_ARB_STATS_EN
            chk($sformatf("t6_stat%0d_p%0d", k, p), stat[k][p*32 +: 32], tx_cnt[k][p]);
`else
            chk($sformatf("t6_stat%0d_p%0d", k, p), stat[k][p*32 +: 32], 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
